// File: rtl/bus_dma_master_if.sv
// Shared-bus master slot signals for the 64-bit 2-master/2-slave bus.
// The master drives request/address/data and the fabric returns grant and read data.
interface bus_dma_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              m_req;
    logic              m_wr;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_dout;
    logic              m_grant;
    logic [DATA_W-1:0] m_din;

    modport master (
        output m_req,
        output m_wr,
        output m_address,
        output m_dout,
        input  m_grant,
        input  m_din
    );

    modport slave (
        input  m_req,
        input  m_wr,
        input  m_address,
        input  m_dout,
        output m_grant,
        output m_din
    );
endinterface

// File: rtl/bus_dma_master.sv
// Word-copy bus initiator: one read then one write per word, bus held for the whole copy.
// Define BUS_DMA_CSUM_EN to add the csum port (XOR of every counted write).
//
// state | meaning
// IDLE  | waiting for start
// REQ   | bus requested, waiting for grant
// RD    | source address on the bus
// CAP   | read data captured from m_din
// WR    | destination address and data on the bus
// NEXT  | advance pointers, decrement count
// DONE  | bus released, done pulse
module bus_dma_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    bus_dma_master_if.master  bus,
    output logic              busy,
    output logic              done
`ifdef BUS_DMA_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;

    // Outputs are registered with the values of the state being entered;
    // bus.m_dout doubles as the word buffer between CAP and WR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            src_ptr       <= '0;
            dst_ptr       <= '0;
            count         <= '0;
            bus.m_req     <= 1'b0;
            bus.m_wr      <= 1'b0;
            bus.m_address <= '0;
            bus.m_dout    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef BUS_DMA_CSUM_EN
            csum          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= len;
`ifdef BUS_DMA_CSUM_EN
                        csum    <= '0;
`endif
                        if (len != '0) begin
                            state     <= S_REQ;
                            busy      <= 1'b1;
                            bus.m_req <= 1'b1;
                            bus.m_wr  <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.m_grant) begin
                        state         <= S_RD;
                        bus.m_address <= src_ptr;
                        bus.m_wr      <= 1'b0;
                    end
                end
                S_RD: begin
                    state <= bus.m_grant ? S_CAP : S_REQ;
                end
                S_CAP: begin
                    if (bus.m_grant) begin
                        state         <= S_WR;
                        bus.m_dout    <= bus.m_din;
                        bus.m_address <= dst_ptr;
                        bus.m_wr      <= 1'b1;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_WR: begin
                    bus.m_wr <= 1'b0;
                    if (bus.m_grant) begin
                        state <= S_NEXT;
`ifdef BUS_DMA_CSUM_EN
                        csum  <= csum ^ bus.m_dout;
`endif
                    end else begin
                        // Write was not seen by the slave; redo the whole word.
                        state <= S_REQ;
                    end
                end
                S_NEXT: begin
                    src_ptr <= src_ptr + 1'b1;
                    dst_ptr <= dst_ptr + 1'b1;
                    count   <= count - 1'b1;
                    if (count == LEN_W'(1)) begin
                        state     <= S_DONE;
                        bus.m_req <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state         <= S_RD;
                        bus.m_address <= src_ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: flat 256-word memory slave, copy model built from word-copy rules.
module tb_bus_dma_master;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 5;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  len      = '0;
    logic              busy;
    logic              done;
`ifdef BUS_DMA_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    logic              grant = 1'b1;
    logic [DATA_W-1:0] din   = '0;
    logic              ld    = 1'b0;
    logic [DATA_W-1:0] mem       [256];
    logic [DATA_W-1:0] pre_mem   [256];
    logic [DATA_W-1:0] model_mem [256];
    logic [ADDR_W-1:0] wr_a_q [$];
    logic [DATA_W-1:0] wr_d_q [$];
    logic [ADDR_W-1:0] exp_a  [$];
    logic [DATA_W-1:0] exp_d  [$];
    logic [DATA_W-1:0] exp_csum;

    int errors = 0;
    int checks = 0;
    int req_drop = 0;
    int wr_cycles = 0;
    int done_cnt = 0;

    bus_dma_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    assign bus.m_grant = grant;
    assign bus.m_din   = din;

    bus_dma_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
`ifdef BUS_DMA_CSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always #5 clk = ~clk;

    // Slave memory (read data one cycle after the address) plus bus monitors.
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre_mem[i];
        end else if (bus.m_req && bus.m_grant) begin
            if (bus.m_wr) begin
                mem[bus.m_address] <= bus.m_dout;
                wr_a_q.push_back(bus.m_address);
                wr_d_q.push_back(bus.m_dout);
            end else begin
                din <= mem[bus.m_address];
            end
        end
        if (busy !== bus.m_req) req_drop <= req_drop + 1;
        if (bus.m_wr === 1'b1) wr_cycles <= wr_cycles + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) pre_mem[i] = {$urandom, $urandom};
    endtask

    task automatic load_mem();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Expected result of copying n words in ascending order, addresses modulo 256.
    task automatic build_model(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] a_s;
        logic [7:0] a_d;
        for (int i = 0; i < 256; i++) model_mem[i] = pre_mem[i];
        exp_a.delete();
        exp_d.delete();
        exp_csum = '0;
        for (int i = 0; i < n; i++) begin
            a_s = 8'((int'(s) + i) % 256);
            a_d = 8'((int'(d) + i) % 256);
            model_mem[a_d] = model_mem[a_s];
            exp_a.push_back(a_d);
            exp_d.push_back(model_mem[a_d]);
            exp_csum ^= model_mem[a_d];
        end
    endtask

    function automatic int seq_errs(input int base);
        int e;
        if (wr_a_q.size() - base != exp_a.size()) return -1;
        e = 0;
        for (int i = 0; i < exp_a.size(); i++)
            if (wr_a_q[base+i] !== exp_a[i] || wr_d_q[base+i] !== exp_d[i]) e++;
        return e;
    endfunction

    function automatic int mem_errs();
        int e;
        e = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) e++;
        return e;
    endfunction

    task automatic pulse_start(input logic [7:0] s, input logic [7:0] d, input logic [4:0] l);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
    endtask

    // n counts negedges after the start edge; done in cycle n means n edges after start.
    task automatic wait_done(input int budget, output int n);
        int k;
        n = -1;
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        len     = 5'd3;
        repeat (2) @(negedge clk);
        checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", bus.m_req); end
        checks++; if (bus.m_wr !== 1'b0) begin errors++; $display("FAIL reset_m_wr: got %b want 0", bus.m_wr); end
        checks++; if (bus.m_address !== 8'h00) begin errors++; $display("FAIL reset_m_address: got %h want 00", bus.m_address); end
        checks++; if (bus.m_dout !== 64'h0) begin errors++; $display("FAIL reset_m_dout: got %h want 0", bus.m_dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef BUS_DMA_CSUM_EN
        checks++; if (csum !== 64'h0) begin errors++; $display("FAIL reset_csum: got %h want 0", csum); end
`endif
        start   = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_single_word();
        int n;
        int base;
        fill_random();
        pre_mem[8'h01] = 64'h2;
        load_mem();
        build_model(8'h01, 8'h21, 1);
        base = wr_a_q.size();
        pulse_start(8'h01, 8'h21, 5'd1);
        wait_done(100, n);
        // REQ + RD/CAP/WR/NEXT + DONE: done is the 7th cycle counting the start cycle.
        checks++; if (n !== 6) begin errors++; $display("FAIL single_latency: got %0d want 6", n); end
        checks++; if (mem[8'h21] !== 64'h2) begin errors++; $display("FAIL single_data: got %h want 2", mem[8'h21]); end
        checks++; if (seq_errs(base) !== 0) begin errors++; $display("FAIL single_wr_seq: got %0d want 0", seq_errs(base)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", busy); end
`ifdef BUS_DMA_CSUM_EN
        checks++; if (csum !== 64'h2) begin errors++; $display("FAIL single_csum: got %h want 2", csum); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
    endtask

    task automatic test_burst();
        int n;
        int base;
        int rd0;
        int wc0;
        fill_random();
        pre_mem[0] = 64'd1; pre_mem[1] = 64'd2; pre_mem[2] = 64'd4; pre_mem[3] = 64'd6;
        load_mem();
        build_model(8'h00, 8'h20, 4);
        base = wr_a_q.size();
        rd0 = req_drop;
        wc0 = wr_cycles;
        pulse_start(8'h00, 8'h20, 5'd4);
        wait_done(200, n);
        checks++; if (n !== 18) begin errors++; $display("FAIL burst_latency: got %0d want 18", n); end
        checks++; if (mem_errs() !== 0) begin errors++; $display("FAIL burst_mem: got %0d bad words want 0", mem_errs()); end
        checks++; if (seq_errs(base) !== 0) begin errors++; $display("FAIL burst_wr_seq: got %0d want 0", seq_errs(base)); end
        checks++; if (req_drop - rd0 !== 0) begin errors++; $display("FAIL burst_req_drop: got %0d want 0", req_drop - rd0); end
        checks++; if (wr_cycles - wc0 !== 4) begin errors++; $display("FAIL burst_wr_cycles: got %0d want 4", wr_cycles - wc0); end
`ifdef BUS_DMA_CSUM_EN
        checks++; if (csum !== 64'h1) begin errors++; $display("FAIL burst_csum: got %h want 1", csum); end
`endif
    endtask

    task automatic test_wrap();
        int n;
        int base;
        fill_random();
        load_mem();
        build_model(8'hFE, 8'h10, 3);
        base = wr_a_q.size();
        pulse_start(8'hFE, 8'h10, 5'd3);
        wait_done(200, n);
        checks++; if (n !== 14) begin errors++; $display("FAIL wrap_latency: got %0d want 14", n); end
        checks++; if (seq_errs(base) !== 0) begin errors++; $display("FAIL wrap_wr_seq: got %0d want 0", seq_errs(base)); end
        checks++; if (mem_errs() !== 0) begin errors++; $display("FAIL wrap_mem: got %0d bad words want 0", mem_errs()); end
    endtask

    task automatic test_grant_loss();
        int n;
        int k;
        int base;
        int rd0;
        int wc0;
        fill_random();
        load_mem();
        build_model(8'h30, 8'h50, 3);
        base = wr_a_q.size();
        rd0 = req_drop;
        wc0 = wr_cycles;
        pulse_start(8'h30, 8'h50, 5'd3);
        n = -1;
        k = 0;
        // Word 2 is in CAP during cycle 7; grant is low for cycles 7..9.
        while (k < 300) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            grant = !(k >= 7 && k <= 9);
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
        grant = 1'b1;
        checks++; if (n !== 19) begin errors++; $display("FAIL gloss_latency: got %0d want 19", n); end
        checks++; if (seq_errs(base) !== 0) begin errors++; $display("FAIL gloss_wr_seq: got %0d want 0", seq_errs(base)); end
        checks++; if (mem_errs() !== 0) begin errors++; $display("FAIL gloss_mem: got %0d bad words want 0", mem_errs()); end
        checks++; if (req_drop - rd0 !== 0) begin errors++; $display("FAIL gloss_req_drop: got %0d want 0", req_drop - rd0); end
        checks++; if (wr_cycles - wc0 !== 3) begin errors++; $display("FAIL gloss_wr_cycles: got %0d want 3", wr_cycles - wc0); end
`ifdef BUS_DMA_CSUM_EN
        checks++; if (csum !== exp_csum) begin errors++; $display("FAIL gloss_csum: got %h want %h", csum, exp_csum); end
`endif
    endtask

    task automatic test_len_zero();
        int n;
        int base;
        int wc0;
        base = wr_a_q.size();
        wc0 = wr_cycles;
        pulse_start(8'h05, 8'h06, 5'd0);
        wait_done(20, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL len0_latency: got %0d want 1", n); end
        checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL len0_m_req: got %b want 0", bus.m_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (wr_a_q.size() - base !== 0 || wr_cycles - wc0 !== 0) begin
            errors++; $display("FAIL len0_writes: got %0d want 0", wr_a_q.size() - base);
        end
`ifdef BUS_DMA_CSUM_EN
        checks++; if (csum !== 64'h0) begin errors++; $display("FAIL len0_csum: got %h want 0", csum); end
`endif
    endtask

    task automatic test_start_while_busy();
        int n;
        int k;
        int base;
        int dc0;
        fill_random();
        load_mem();
        build_model(8'h40, 8'h60, 2);
        base = wr_a_q.size();
        pulse_start(8'h40, 8'h60, 5'd2);
        n = -1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                src_addr = 8'h80;
                dst_addr = 8'h90;
                len      = 5'd7;
            end
            k++;
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
        start = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL busy_start_latency: got %0d want 10", n); end
        dc0 = done_cnt;
        repeat (10) @(negedge clk);
        checks++; if (seq_errs(base) !== 0) begin errors++; $display("FAIL busy_start_wr_seq: got %0d want 0", seq_errs(base)); end
        checks++; if (busy !== 1'b0 || done_cnt - dc0 !== 1) begin
            errors++; $display("FAIL busy_start_restart: got busy=%b dones=%0d want busy=0 dones=1", busy, done_cnt - dc0);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int dc0;
        fill_random();
        load_mem();
        dc0 = done_cnt;
        pulse_start(8'h00, 8'hA0, 5'd4);
        for (k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (bus.m_req !== 1'b0 || busy !== 1'b0 || bus.m_wr !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got req=%b busy=%b wr=%b want 0 0 0", bus.m_req, busy, bus.m_wr);
        end
        repeat (30) @(negedge clk);
        checks++; if (done_cnt - dc0 !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - dc0); end
        checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got %b want 0", bus.m_req); end
    endtask

    task automatic test_random();
        int n;
        int k;
        int base;
        logic [7:0] s;
        logic [7:0] d;
        logic [4:0] l;
        for (int it = 0; it < 6; it++) begin
            fill_random();
            load_mem();
            s = 8'($urandom);
            d = 8'($urandom);
            l = 5'($urandom_range(1, 31));
            build_model(s, d, int'(l));
            base = wr_a_q.size();
            pulse_start(s, d, l);
            n = -1;
            k = 0;
            while (k < 3000) begin
                @(negedge clk);
                start = 1'b0;
                k++;
                grant = ($urandom_range(0, 9) != 0);
                if (done === 1'b1) begin
                    n = k;
                    break;
                end
            end
            grant = 1'b1;
            checks++; if (n < 0) begin errors++; $display("FAIL rand%0d_done: got timeout want done", it); end
            checks++; if (seq_errs(base) !== 0) begin errors++; $display("FAIL rand%0d_wr_seq: got %0d want 0", it, seq_errs(base)); end
            checks++; if (mem_errs() !== 0) begin errors++; $display("FAIL rand%0d_mem: got %0d bad words want 0", it, mem_errs()); end
`ifdef BUS_DMA_CSUM_EN
            checks++; if (csum !== exp_csum) begin errors++; $display("FAIL rand%0d_csum: got %h want %h", it, csum, exp_csum); end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        fill_random();
        test_reset();
        load_mem();
        test_single_word();
        test_burst();
        test_wrap();
        test_grant_loss();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
